// File: rtl/cmt_job_sequencer.sv
// Job-level sequencer for the CMT 3-direction matrix-multiply pipeline: sizes the DMA
// transfers, routes kernel/data words, counts results, flushes and signals completion.
// Optional build macro CMT_SEQ_PERF_EN adds cycle and stall performance counters.
module cmt_job_sequencer #(
    parameter int WIDTH        = 64,
    parameter int N_MAX        = 32,
    parameter int N_WIDTH      = 6,
    parameter int CNT_WIDTH    = 20,
    parameter int WORDS_PER_CL = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [N_WIDTH-1:0]   n_size,
    output logic [CNT_WIDTH-1:0] rd_size,
    output logic [CNT_WIDTH-1:0] wr_size,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic                 stall,
    output logic [WIDTH-1:0]     kernel_out,
    output logic                 kernel_vld,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_vld,
    input  logic                 res_vld,
    output logic                 flush,
    input  logic                 dma_wr_done,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
`ifdef CMT_SEQ_PERF_EN
    ,
    output logic [31:0]          cyc_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int CL_SH = $clog2(WORDS_PER_CL);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CALC   = 4'd1,
        S_KERNEL = 4'd2,
        S_DATA   = 4'd3,
        S_DRAIN  = 4'd4,
        S_FLUSH  = 4'd5,
        S_WAIT   = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_nn;
    logic [CNT_WIDTH-1:0] r_nnn;
    logic [CNT_WIDTH-1:0] r_wr_words;
    logic                 r_n_bad;
    logic [CNT_WIDTH-1:0] r_wcnt;
    logic [CNT_WIDTH-1:0] r_rcnt;
    logic                 r_dma_seen;

    logic [CNT_WIDTH-1:0] w_n;
    logic [CNT_WIDTH-1:0] w_nn;
    logic [CNT_WIDTH-1:0] w_nnn;
    logic [CNT_WIDTH-1:0] w_rd_words;
    logic [CNT_WIDTH-1:0] w_wr_words;
    logic                 w_n_bad;
    logic                 w_go_start;
    logic                 w_stream;
    logic                 w_xfer;
    logic                 w_k_last;
    logic                 w_d_last;
    logic                 w_res_window;
    logic                 w_res_en;
    logic                 w_partial_cl;

    // Sizes are computed from n_size while still in IDLE so they are visible during CALC.
    assign w_n          = CNT_WIDTH'(n_size);
    assign w_nn         = w_n * w_n;
    assign w_nnn        = w_nn * w_n;
    assign w_rd_words   = w_nn + w_nnn;
    assign w_wr_words   = CNT_WIDTH'(3) * w_nnn;
    assign w_n_bad      = (n_size == {N_WIDTH{1'b0}}) || (n_size > N_WIDTH'(N_MAX));
    assign w_go_start   = (r_state == S_IDLE) && go;

    assign w_stream     = (r_state == S_KERNEL) || (r_state == S_DATA);
    assign in_rdy       = w_stream && !stall;
    assign w_xfer       = in_vld && in_rdy;
    assign kernel_out   = in_data;
    assign data_out     = in_data;
    assign kernel_vld   = w_xfer && (r_state == S_KERNEL);
    assign data_vld     = w_xfer && (r_state == S_DATA);
    assign w_k_last     = kernel_vld && (r_wcnt == r_nn - CNT_WIDTH'(1));
    assign w_d_last     = data_vld && (r_wcnt == r_nnn - CNT_WIDTH'(1));

    assign w_res_window = w_stream || (r_state == S_DRAIN) || (r_state == S_FLUSH) ||
                          (r_state == S_WAIT);
    assign w_res_en     = res_vld && w_res_window && (r_rcnt < r_wr_words);
    assign w_partial_cl = (r_wr_words & CNT_WIDTH'(WORDS_PER_CL - 1)) != {CNT_WIDTH{1'b0}};

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (go) w_state_nxt = S_CALC; else w_state_nxt = S_IDLE;
            S_CALC:   if (r_n_bad) w_state_nxt = S_ERR; else w_state_nxt = S_KERNEL;
            S_KERNEL: if (w_k_last) w_state_nxt = S_DATA; else w_state_nxt = S_KERNEL;
            S_DATA:   if (w_d_last) w_state_nxt = S_DRAIN; else w_state_nxt = S_DATA;
            S_DRAIN: begin
                if (r_rcnt == r_wr_words) begin
                    if (w_partial_cl) w_state_nxt = S_FLUSH; else w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_FLUSH:  w_state_nxt = S_WAIT;
            S_WAIT:   if (dma_wr_done || r_dma_seen) w_state_nxt = S_DONE; else w_state_nxt = S_WAIT;
            S_DONE:   if (!go) w_state_nxt = S_IDLE; else w_state_nxt = S_DONE;
            S_ERR:    if (!go) w_state_nxt = S_IDLE; else w_state_nxt = S_ERR;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register with status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            flush   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) &&
                       (w_state_nxt != S_ERR);
            done    <= (w_state_nxt == S_DONE) || (w_state_nxt == S_ERR);
            cfg_err <= (w_state_nxt == S_ERR);
            flush   <= (w_state_nxt == S_FLUSH);
        end
    end

    // Job configuration captured when a job is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nn       <= {CNT_WIDTH{1'b0}};
            r_nnn      <= {CNT_WIDTH{1'b0}};
            r_wr_words <= {CNT_WIDTH{1'b0}};
            r_n_bad    <= 1'b0;
            rd_size    <= {CNT_WIDTH{1'b0}};
            wr_size    <= {CNT_WIDTH{1'b0}};
        end else if (w_go_start) begin
            r_nn       <= w_nn;
            r_nnn      <= w_nnn;
            r_wr_words <= w_wr_words;
            r_n_bad    <= w_n_bad;
            rd_size    <= (w_rd_words + CNT_WIDTH'(WORDS_PER_CL - 1)) >> CL_SH;
            wr_size    <= (w_wr_words + CNT_WIDTH'(WORDS_PER_CL - 1)) >> CL_SH;
        end
    end

    // Word/result counters; the word counter restarts for the data phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt     <= {CNT_WIDTH{1'b0}};
            r_rcnt     <= {CNT_WIDTH{1'b0}};
            r_dma_seen <= 1'b0;
        end else if (w_go_start) begin
            r_wcnt     <= {CNT_WIDTH{1'b0}};
            r_rcnt     <= {CNT_WIDTH{1'b0}};
            r_dma_seen <= 1'b0;
        end else begin
            if (w_k_last) begin
                r_wcnt <= {CNT_WIDTH{1'b0}};
            end else if (w_xfer) begin
                r_wcnt <= r_wcnt + CNT_WIDTH'(1);
            end
            if (w_res_en) begin
                r_rcnt <= r_rcnt + CNT_WIDTH'(1);
            end
            if (dma_wr_done && busy) begin
                r_dma_seen <= 1'b1;
            end
        end
    end

`ifdef CMT_SEQ_PERF_EN
    // Saturating performance counters, cleared when a job is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt   <= 32'd0;
            stall_cnt <= 32'd0;
        end else if (w_go_start) begin
            cyc_cnt   <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (busy && (cyc_cnt != 32'hFFFF_FFFF)) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (w_stream && in_vld && stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmt_job_sequencer.sv
// Directed self-checking bench for cmt_job_sequencer: sizing, kernel/data routing,
// stall, flush, error N, mid-job reset, go toggling and sticky DMA completion.
module tb_cmt_job_sequencer;

    localparam int WIDTH     = 64;
    localparam int N_WIDTH   = 6;
    localparam int CNT_WIDTH = 20;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 go = 1'b0;
    logic [N_WIDTH-1:0]   n_size = '0;
    logic [CNT_WIDTH-1:0] rd_size, wr_size;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 in_vld = 1'b0;
    logic                 in_rdy;
    logic                 stall = 1'b0;
    logic [WIDTH-1:0]     kernel_out, data_out;
    logic                 kernel_vld, data_vld;
    logic                 res_vld = 1'b0;
    logic                 flush;
    logic                 dma_wr_done = 1'b0;
    logic                 busy, done, cfg_err;
`ifdef CMT_SEQ_PERF_EN
    logic [31:0]          cyc_cnt, stall_cnt;
`endif

    cmt_job_sequencer dut (
        .clk(clk), .rst(rst), .go(go), .n_size(n_size),
        .rd_size(rd_size), .wr_size(wr_size),
        .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy), .stall(stall),
        .kernel_out(kernel_out), .kernel_vld(kernel_vld),
        .data_out(data_out), .data_vld(data_vld),
        .res_vld(res_vld), .flush(flush), .dma_wr_done(dma_wr_done),
        .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef CMT_SEQ_PERF_EN
        , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int kcnt, dcnt, fl, both, rdy_cnt, stall_rdy, done_rise, widx;
    logic [WIDTH-1:0] last_k, first_d;
    logic prev_done = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample outputs at negedge, then advance the input word after the active edge.
    task automatic tick();
        logic xfer;
        @(negedge clk);
        xfer = in_vld && in_rdy;
        if (kernel_vld) begin kcnt++; last_k = kernel_out; end
        if (data_vld) begin dcnt++; if (dcnt == 1) first_d = data_out; end
        if (kernel_vld && data_vld) both++;
        if (flush) fl++;
        if (in_rdy) rdy_cnt++;
        if (stall && in_rdy) stall_rdy++;
        if (done && !prev_done) done_rise++;
        prev_done = done;
        @(posedge clk);
        #1;
        if (xfer) begin widx++; in_data = 64'(widx); end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic start(input int n, input int exp_rd, input int exp_wr);
        kcnt = 0; dcnt = 0; fl = 0; both = 0; rdy_cnt = 0; stall_rdy = 0;
        done_rise = 0; widx = 0; in_data = '0; in_vld = 1'b1;
        n_size = N_WIDTH'(n);
        go = 1'b1;
        tick();
        check_eq("rd_size", 64'(rd_size), 64'(exp_rd));
        check_eq("wr_size", 64'(wr_size), 64'(exp_wr));
        check_eq("busy_calc", 64'(busy), 64'd1);
    endtask

    task automatic wait_cnt(input int sel, input int target, input string tag);
        int budget = 3000;
        while (((sel == 0) ? kcnt : dcnt) < target && budget > 0) begin
            tick();
            budget--;
        end
        check_eq(tag, 64'((sel == 0) ? kcnt : dcnt), 64'(target));
    endtask

    task automatic feed_res(input int n);
        res_vld = 1'b1;
        ticks(n);
        res_vld = 1'b0;
    endtask

    task automatic finish_job();
        go = 1'b0; dma_wr_done = 1'b0; in_vld = 1'b0;
        ticks(2);
        check_eq("idle_done", 64'(done), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        // Reset state
        ticks(3);
        check_eq("rst_outs", 64'({busy, done, cfg_err, flush, in_rdy}), 64'd0);
        check_eq("rst_sizes", 64'({rd_size, wr_size}), 64'd0);
        rst = 1'b1;
        ticks(2);
        check_eq("idle_busy0", 64'(busy), 64'd0);

        // N=8 full job, no partial line
        start(8, 72, 192);
        wait_cnt(0, 64, "t1_kwords");
        wait_cnt(1, 512, "t1_dwords");
        check_eq("t1_last_k", last_k, 64'd63);
        check_eq("t1_first_d", first_d, 64'd64);
        check_eq("t1_both", 64'(both), 64'd0);
        feed_res(1536);
        ticks(3);
        check_eq("t1_noflush", 64'(fl), 64'd0);
        check_eq("t1_busy_wait", 64'(busy), 64'd1);
        check_eq("t1_kcnt_total", 64'(kcnt), 64'd64);
        check_eq("t1_dcnt_total", 64'(dcnt), 64'd512);
        dma_wr_done = 1'b1;
        ticks(2);
        check_eq("t1_done", 64'({done, busy, cfg_err}), 64'b100);
        finish_job();

        // N=3 with partial last line
        start(3, 5, 11);
        wait_cnt(0, 9, "t2_kwords");
        wait_cnt(1, 27, "t2_dwords");
        check_eq("t2_last_k", last_k, 64'd8);
        check_eq("t2_first_d", first_d, 64'd9);
        feed_res(80);
        ticks(3);
        check_eq("t2_flush_early", 64'(fl), 64'd0);
        feed_res(1);
        ticks(3);
        check_eq("t2_flush_once", 64'(fl), 64'd1);
        check_eq("t2_waiting", 64'({busy, done}), 64'b10);
        dma_wr_done = 1'b1;
        tick();
        dma_wr_done = 1'b0;
        tick();
        check_eq("t2_done", 64'({done, busy}), 64'b10);
        finish_job();

        // Illegal N: 0 and 33
        start(0, 0, 0);
        tick();
        check_eq("t3a_err", 64'({cfg_err, done, busy}), 64'b110);
        ticks(4);
        check_eq("t3a_no_rdy", 64'(rdy_cnt), 64'd0);
        finish_job();
        check_eq("t3a_err_clr", 64'(cfg_err), 64'd0);
        start(33, 4629, 13477);
        tick();
        check_eq("t3b_err", 64'({cfg_err, done, busy}), 64'b110);
        ticks(4);
        check_eq("t3b_no_rdy", 64'(rdy_cnt), 64'd0);
        finish_job();

        // N=8 with a 10-cycle stall after kernel word 30
        start(8, 72, 192);
        wait_cnt(0, 30, "t4_k30");
        stall = 1'b1;
        ticks(10);
        check_eq("t4_k_hold", 64'(kcnt), 64'd30);
        check_eq("t4_rdy_stall", 64'(stall_rdy), 64'd0);
        stall = 1'b0;
        wait_cnt(0, 64, "t4_kwords");
        wait_cnt(1, 512, "t4_dwords");
        check_eq("t4_last_k", last_k, 64'd63);
        check_eq("t4_first_d", first_d, 64'd64);
        feed_res(1536);
        ticks(3);
        check_eq("t4_noflush", 64'(fl), 64'd0);
        dma_wr_done = 1'b1;
        ticks(2);
        check_eq("t4_done", 64'(done), 64'd1);
        finish_job();

        // Reset in the middle of the data phase, then a clean N=2 job
        start(8, 72, 192);
        wait_cnt(1, 100, "t5_d100");
        go = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("t5_rst_outs", 64'({busy, done, cfg_err, flush, in_rdy, kernel_vld, data_vld}), 64'd0);
        check_eq("t5_rst_sizes", 64'({rd_size, wr_size}), 64'd0);
        ticks(2);
        rst = 1'b1;
        tick();
        start(2, 2, 3);
        wait_cnt(0, 4, "t5_kwords");
        wait_cnt(1, 8, "t5_dwords");
        feed_res(24);
        ticks(3);
        check_eq("t5_noflush", 64'(fl), 64'd0);
        dma_wr_done = 1'b1;
        ticks(2);
        check_eq("t5_done", 64'(done), 64'd1);
        finish_job();

        // go toggling while busy, early DMA done, surplus results
        start(3, 5, 11);
        wait_cnt(0, 9, "t6_kwords");
        wait_cnt(1, 5, "t6_d5");
        go = 1'b0; tick();
        go = 1'b1; tick();
        go = 1'b0; tick();
        go = 1'b1; dma_wr_done = 1'b1; tick();
        dma_wr_done = 1'b0;
        wait_cnt(1, 27, "t6_dwords");
        check_eq("t6_busy", 64'(busy), 64'd1);
        check_eq("t6_kcnt", 64'(kcnt), 64'd9);
        feed_res(86);
        ticks(4);
        check_eq("t6_flush_once", 64'(fl), 64'd1);
        check_eq("t6_done", 64'(done), 64'd1);
        ticks(5);
        check_eq("t6_single_done", 64'(done_rise), 64'd1);
        check_eq("t6_rd_hold", 64'(rd_size), 64'd5);
        finish_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
